// File: rtl/star_row_scheduler_if.sv
// Host-side job/abort controls and STAR core start/done/abort handshake,
// bundled for the row scheduler.
interface star_row_scheduler_if #(
    parameter int ADDR_W = 9,
    parameter int ROW_W  = 5
);
    logic              start;
    logic [ROW_W-1:0]  cfg_rows;
    logic [ADDR_W-1:0] cfg_base;
    logic [ADDR_W-1:0] cfg_stride;
    logic              abort;
    logic              err_clr;
    logic              core_done;
    logic              core_start;
    logic [ADDR_W-1:0] core_base;
    logic              core_abort;
    logic              busy;
    logic              done;
    logic              err;
    logic [ROW_W-1:0]  row_idx;

    modport master (
        output start, cfg_rows, cfg_base, cfg_stride, abort, err_clr, core_done,
        input  core_start, core_base, core_abort, busy, done, err, row_idx
    );

    modport slave (
        input  start, cfg_rows, cfg_base, cfg_stride, abort, err_clr, core_done,
        output core_start, core_base, core_abort, busy, done, err, row_idx
    );
endinterface

// File: rtl/star_row_scheduler.sv
// Row-level sequencer for the STAR softmax engine: launches the core once per
// row at base + row*stride, guards each row with a watchdog, handles abort.
module star_row_scheduler #(
    parameter int ADDR_W  = 9,
    parameter int ROW_W   = 5,
    parameter int TIMEOUT = 255
) (
    input logic                 clk,
    input logic                 reset,
    star_row_scheduler_if.slave bus
);

    // Watchdog only needs to reach TIMEOUT-1; expiry is detected on the increment.
    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  rows_q, rows_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [ROW_W-1:0]  row_idx_q, row_idx_d;
    logic [ADDR_W-1:0] core_base_q, core_base_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic              core_abort_q, core_abort_d;

    function automatic logic [ADDR_W-1:0] row_addr(
        input logic [ADDR_W-1:0] base,
        input logic [ROW_W-1:0]  idx,
        input logic [ADDR_W-1:0] stride
    );
        logic [ADDR_W+ROW_W-1:0] prod;
        prod = {{ADDR_W{1'b0}}, idx} * {{ROW_W{1'b0}}, stride};
        return base + prod[ADDR_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            rows_q       <= '0;
            base_q       <= '0;
            stride_q     <= '0;
            row_idx_q    <= '0;
            core_base_q  <= '0;
            wdog_q       <= '0;
            core_abort_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rows_q       <= rows_d;
            base_q       <= base_d;
            stride_q     <= stride_d;
            row_idx_q    <= row_idx_d;
            core_base_q  <= core_base_d;
            wdog_q       <= wdog_d;
            core_abort_q <= core_abort_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rows_d       = rows_q;
        base_d       = base_q;
        stride_d     = stride_q;
        row_idx_d    = row_idx_q;
        core_base_d  = core_base_q;
        wdog_d       = wdog_q;
        core_abort_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.cfg_rows != '0) begin
                        rows_d      = bus.cfg_rows;
                        base_d      = bus.cfg_base;
                        stride_d    = bus.cfg_stride;
                        row_idx_d   = '0;
                        core_base_d = bus.cfg_base;
                        state_d     = S_LAUNCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            // core_start goes out this cycle regardless; an abort is honoured right after.
            S_LAUNCH: begin
                wdog_d = '0;
                if (bus.abort) begin
                    core_abort_d = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                wdog_d = wdog_q + WD_W'(1);
                if (bus.abort) begin
                    core_abort_d = 1'b1;
                    state_d      = S_IDLE;
                end else if (bus.core_done) begin
                    if (row_idx_q == rows_q - ROW_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        row_idx_d   = row_idx_q + ROW_W'(1);
                        core_base_d = row_addr(base_q, row_idx_q + ROW_W'(1), stride_q);
                        state_d     = S_LAUNCH;
                    end
                end else if (wdog_q == WD_LAST) begin
                    core_abort_d = 1'b1;
                    state_d      = S_ERR;
                end
            end

            S_DONE: state_d = S_IDLE;

            S_ERR: begin
                if (bus.err_clr) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign bus.core_start = (state_q == S_LAUNCH);
    assign bus.core_base  = core_base_q;
    assign bus.core_abort = core_abort_q;
    assign bus.busy       = (state_q == S_LAUNCH) || (state_q == S_WAIT);
    assign bus.done       = (state_q == S_DONE);
    assign bus.err        = (state_q == S_ERR);
    assign bus.row_idx    = row_idx_q;

endmodule

// File: tb/tb_star_row_scheduler.sv
// Scoreboard bench for star_row_scheduler: the driver derives each job's event
// timeline from the row rules and queues it; a monitor matches DUT pulses.
module tb_star_row_scheduler;

    localparam int ADDR_W  = 9;
    localparam int ROW_W   = 5;
    localparam int TIMEOUT = 48;

    localparam int K_LAUNCH = 0;
    localparam int K_DONE   = 1;
    localparam int K_ABORT  = 2;

    typedef struct {
        int cyc;
        int kind;
        int base;
        int idx;
        int errf;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    ev_t  q[$];
    bit   in_job = 1'b0;
    int   last_idx = 0;
    ev_t  me;
    int   gk;

    star_row_scheduler_if #(.ADDR_W(ADDR_W), .ROW_W(ROW_W)) bus ();

    star_row_scheduler #(
        .ADDR_W (ADDR_W),
        .ROW_W  (ROW_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     nm, act, act, exp_v, exp_v, cyc);
        end
    endtask

    function automatic int exp_addr(input int b, input int s, input int r);
        return (b + r * s) % (1 << ADDR_W);
    endfunction

    function automatic void push(input int c, input int k, input int b, input int i, input int e);
        ev_t ev;
        ev.cyc  = c;
        ev.kind = k;
        ev.base = b;
        ev.idx  = i;
        ev.errf = e;
        q.push_back(ev);
        if (k == K_LAUNCH) last_idx = i;
    endfunction

    task automatic quiet();
        bus.start     = 1'b0;
        bus.err_clr   = 1'b0;
        bus.abort     = 1'b0;
        bus.core_done = 1'b0;
    endtask

    task automatic quiet_idle(input int n);
        quiet();
        repeat (n) @(negedge clk);
    endtask

    // Inputs that a busy scheduler must ignore: start with junk config, err_clr.
    task automatic noise();
        bus.start      = ($urandom_range(3) == 0);
        bus.err_clr    = ($urandom_range(3) == 0);
        bus.cfg_rows   = ROW_W'($urandom);
        bus.cfg_base   = ADDR_W'($urandom);
        bus.cfg_stride = ADDR_W'($urandom);
    endtask

    // Inputs that IDLE/DONE must ignore.
    task automatic idle_noise(input int n);
        repeat (n) begin
            bus.core_done = 1'($urandom_range(1));
            bus.abort     = 1'($urandom_range(1));
            bus.err_clr   = 1'($urandom_range(1));
            @(negedge clk);
        end
        quiet();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_core_start"}, int'(bus.core_start), 0);
        chk({tag, "_core_base"},  int'(bus.core_base),  0);
        chk({tag, "_core_abort"}, int'(bus.core_abort), 0);
        chk({tag, "_busy"},       int'(bus.busy),       0);
        chk({tag, "_done"},       int'(bus.done),       0);
        chk({tag, "_err"},        int'(bus.err),        0);
        chk({tag, "_row_idx"},    int'(bus.row_idx),    0);
    endtask

    // mode: 0 normal, 1 abort, 2 abort together with core_done, 3 core silent (timeout).
    // sel_row/sel_off pick the row and cycles-after-core_start for modes 1-3.
    // fixed_d > 0 forces the core_done latency of every normal row.
    task automatic run_job(input int rows, input int base, input int stride, input int mode,
                           input int sel_row, input int sel_off, input int fixed_d);
        int L;
        int d;
        bus.start      = 1'b1;
        bus.cfg_rows   = ROW_W'(rows);
        bus.cfg_base   = ADDR_W'(base);
        bus.cfg_stride = ADDR_W'(stride);
        if (rows == 0) begin
            push(cyc + 1, K_DONE, 0, 0, 0);
            @(negedge clk);
            bus.start = 1'b0;
            return;
        end
        L = cyc + 1;
        push(L, K_LAUNCH, exp_addr(base, stride, 0), 0, 0);
        @(negedge clk);
        bus.start = 1'b0;
        for (int r = 0; r < rows; r++) begin
            if (mode == 3 && r == sel_row) begin
                push(L + TIMEOUT + 1, K_ABORT, 0, 0, 1);
                repeat (TIMEOUT + 1) begin
                    noise();
                    @(negedge clk);
                end
                quiet();
                return;
            end
            if ((mode == 1 || mode == 2) && r == sel_row) d = sel_off;
            else if (fixed_d > 0) d = fixed_d;
            else d = $urandom_range(TIMEOUT, 1);
            repeat (d) begin
                noise();
                @(negedge clk);
            end
            quiet();
            if ((mode == 1 || mode == 2) && r == sel_row) begin
                bus.abort = 1'b1;
                if (mode == 2) bus.core_done = 1'b1;
                push(cyc + 1, K_ABORT, 0, 0, 0);
                @(negedge clk);
                quiet();
                return;
            end
            bus.core_done = 1'b1;
            if (r == rows - 1) begin
                push(cyc + 1, K_DONE, 0, 0, 0);
            end else begin
                L = cyc + 1;
                push(L, K_LAUNCH, exp_addr(base, stride, r + 1), r + 1, 0);
            end
            @(negedge clk);
            bus.core_done = 1'b0;
        end
    endtask

    task automatic clear_err();
        chk("err_set", int'(bus.err), 1);
        chk("err_busy", int'(bus.busy), 0);
        repeat (3) begin
            bus.start     = 1'b1;
            bus.cfg_rows  = ROW_W'($urandom_range(31, 1));
            bus.core_done = 1'($urandom_range(1));
            bus.abort     = 1'($urandom_range(1));
            @(negedge clk);
            chk("err_sticky", int'(bus.err), 1);
        end
        quiet();
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("err_cleared", int'(bus.err), 0);
    endtask

    // Monitor: every start/done/abort pulse must match the oldest queued event.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                in_job = 1'b0;
            end else begin
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL missing_event: got nothing, expected kind %0d at cycle %0d (now %0d)",
                             q[0].kind, q[0].cyc, cyc);
                    void'(q.pop_front());
                end
                if (bus.core_start || bus.done || bus.core_abort) begin
                    gk = bus.core_start ? K_LAUNCH : (bus.done ? K_DONE : K_ABORT);
                    if (q.size() == 0 || q[0].cyc != cyc) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none",
                                 gk, cyc);
                    end else begin
                        me = q.pop_front();
                        chk("event_kind", gk, me.kind);
                        if (me.kind == K_LAUNCH) begin
                            chk("core_base", int'(bus.core_base), me.base);
                            chk("row_idx", int'(bus.row_idx), me.idx);
                            in_job = 1'b1;
                        end else begin
                            if (me.kind == K_ABORT) chk("abort_err", int'(bus.err), me.errf);
                            in_job = 1'b0;
                        end
                    end
                end
                chk("busy", int'(bus.busy), int'(in_job));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish, expected finish within time limit");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        int rows;
        int mode;
        int sel;
        reset          = 1'b1;
        bus.cfg_rows   = '0;
        bus.cfg_base   = '0;
        bus.cfg_stride = '0;
        quiet();
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("rst");
        reset = 1'b1;
        quiet_idle(2);

        // Job interrupted by asynchronous reset during WAIT of row 1.
        bus.start      = 1'b1;
        bus.cfg_rows   = ROW_W'(3);
        bus.cfg_base   = ADDR_W'('h123);
        bus.cfg_stride = ADDR_W'(5);
        push(cyc + 1, K_LAUNCH, 'h123, 0, 0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.core_done = 1'b1;
        push(cyc + 1, K_LAUNCH, 'h128, 1, 0);
        @(negedge clk);
        bus.core_done = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_reset_busy", int'(bus.busy), 1);
        chk("pre_reset_row_idx", int'(bus.row_idx), 1);
        #2 reset = 1'b0;
        #1 chk_all_zero("async_rst");
        @(negedge clk);
        reset    = 1'b1;
        last_idx = 0;
        quiet_idle(2);
        run_job(2, 'h0A5, 7, 0, 0, 0, 3);
        quiet_idle(2);

        // Directed jobs.
        run_job(3, 'h010, 32, 0, 0, 0, 40);
        quiet_idle(2);
        run_job(2, 'h1F0, 32, 0, 0, 0, 0);
        quiet_idle(2);
        run_job(0, 'h055, 3, 0, 0, 0, 0);
        quiet_idle(2);
        run_job(3, 'h040, 16, 3, 1, 0, 5);
        clear_err();
        quiet_idle(1);
        run_job(2, 'h100, 9, 0, 0, 0, 0);
        quiet_idle(2);
        run_job(4, 'h020, 11, 1, 1, $urandom_range(5, 1), 4);
        quiet_idle(2);
        run_job(4, 'h000, 3, 2, 1, 6, 2);
        quiet_idle(2);
        run_job(3, 'h1FF, 100, 1, 2, 0, 2);
        quiet_idle(2);
        run_job(2, 'h011, 13, 0, 0, 0, TIMEOUT);
        quiet_idle(2);

        // Spurious core_done/abort/err_clr while idle.
        bus.core_done = 1'b1;
        bus.abort     = 1'b1;
        bus.err_clr   = 1'b1;
        @(negedge clk);
        quiet();
        @(negedge clk);
        chk("idle_row_idx", int'(bus.row_idx), last_idx);
        chk("idle_busy", int'(bus.busy), 0);
        chk("idle_err", int'(bus.err), 0);

        // Maximum row count.
        run_job(31, $urandom_range(511), $urandom_range(511), 0, 0, 0, 0);
        quiet_idle(2);

        // Randomized jobs.
        for (int j = 0; j < 24; j++) begin
            mode = $urandom_range(3);
            rows = $urandom_range(7, (mode == 0) ? 0 : 1);
            sel  = (rows > 0) ? $urandom_range(rows - 1) : 0;
            run_job(rows, $urandom_range(511), $urandom_range(511), mode, sel,
                    $urandom_range(TIMEOUT), 0);
            if (mode == 3) clear_err();
            idle_noise(3);
        end

        quiet_idle(5);
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/star_row_scheduler.md
# star_row_scheduler

Row-level sequencer for the STAR softmax engine. It takes a multi-row job from the host (row count, input base address, row stride), launches the engine once per row with the correct input-memory base address, and waits for each row's completion. It guards every row with a watchdog, supports host abort, and reports job completion and errors. It sits between the host/testbench control interface and the STAR core's start/done/abort handshake.

## Interface
Parameters:
- ADDR_W, 9: width of input-memory addresses (matches core `data_addr`).
- ROW_W, 5: width of row count/index; at most 2^ROW_W − 1 rows per job.
- TIMEOUT, 255: per-row watchdog limit in cycles, ≥ 1.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle job launch request; sampled only in IDLE.
- cfg_rows  in  ROW_W  number of rows in the job.
- cfg_base  in  ADDR_W  input-memory address of row 0.
- cfg_stride  in  ADDR_W  address increment between rows (normally `Input_len`).
- abort  in  1  host abort; effective in LAUNCH/WAIT.
- err_clr  in  1  clears the sticky error; effective in ERR only.
- core_done  in  1  one-cycle pulse from the core: current row finished.
- core_start  out  1  one-cycle pulse: core begins a row.
- core_base  out  ADDR_W  base address for the row being launched; held stable until the next launch.
- core_abort  out  1  one-cycle pulse: core returns to its Init state.
- busy  out  1  high while a job is in progress (LAUNCH/WAIT).
- done  out  1  one-cycle pulse: job completed normally.
- err  out  1  sticky watchdog error.
- row_idx  out  ROW_W  index of the current or last launched row.

## Operation
- States: IDLE, LAUNCH, WAIT, DONE, ERR. Encode as a registered state. All outputs are decoded from registers only, with no input-to-output combinational path.
- Reset (reset = 0) forces asynchronously: state = IDLE; all outputs = 0; row_idx = 0; core_base = 0; watchdog = 0; latched config = 0.
- IDLE:
  - start = 1 with cfg_rows ≠ 0: latch cfg_rows/cfg_base/cfg_stride, set row_idx = 0, go to LAUNCH.
  - start = 1 with cfg_rows = 0: go to DONE. No core_start is issued.
  - abort, err_clr and core_done are ignored.
- LAUNCH (exactly 1 cycle):
  - core_start = 1.
  - core_base = base + row_idx × stride, truncated modulo 2^ADDR_W (wrap-around is legal and silent).
  - Watchdog cleared. Next state: WAIT.
- WAIT: watchdog increments every cycle; priority order:
  1. abort: core_abort pulse next cycle, go to IDLE, no done.
  2. core_done: if row_idx = rows − 1 go to DONE; else row_idx += 1 and go to LAUNCH.
  3. watchdog = TIMEOUT: set err, core_abort pulse, go to ERR.
- LAUNCH with abort = 1: core_start is still issued that cycle. The abort is then taken, with core_abort in the following cycle and a return to IDLE.
- DONE (exactly 1 cycle): done = 1, then IDLE.
- ERR: err stays 1 and busy = 0; start is ignored. err_clr = 1 clears err and goes to IDLE.
- start while busy is ignored; the latched config never changes mid-job.
- core_done outside WAIT is ignored and does not affect row_idx.
- busy = 1 exactly in LAUNCH and WAIT.

## Timing
- start sampled at edge N: LAUNCH during cycle N+1, core_start high for that cycle, core_base valid from that cycle.
- core_done sampled at edge M (not the last row): next core_start in cycle M+1. The minimum inter-row gap is 1 cycle.
- Last core_done at edge M: done high in cycle M+1; busy low from cycle M+1.
- Watchdog: core_start in cycle L with no core_done gives err = 1 and core_abort = 1 in cycle L+TIMEOUT+1.
- core_done arriving on the same cycle the watchdog hits TIMEOUT: core_done wins, with no error.
- Reset mid-job: outputs drop immediately (asynchronous). The first start after reset release launches at row 0.

## Test plan
- Reset values: hold reset = 0 mid-WAIT → all outputs 0 immediately. After release, start with cfg_rows = 2 → core_start 1 cycle later, core_base = cfg_base.
- Multi-row job: rows = 3, base = 0x010, stride = 32, core_done returned 40 cycles after each core_start → core_base sequence 0x010, 0x030, 0x050; row_idx 0, 1, 2; single done pulse 1 cycle after the third core_done; busy high throughout.
- Wrap and zero rows:
  - base = 0x1F0, stride = 32, rows = 2 → core_base 0x1F0 then 0x010.
  - rows = 0 → done the cycle after start, no core_start.
- Watchdog: TIMEOUT = 8, core never responds → err and core_abort in cycle L+9; start ignored while err = 1; err_clr → IDLE; a new job runs normally.
- Abort: abort during WAIT of row 1 of 4 → core_abort next cycle, IDLE, no done, busy low. Abort and core_done in the same cycle → abort wins.
- Spurious and overlapping inputs:
  - core_done in IDLE → no state or row_idx change.
  - start during WAIT → ignored, config unchanged.
  - core_done on the same cycle as watchdog expiry → no err.
